// File: rtl/mesh_pkg.sv
// Shared constants, types and helpers for the mesh router local-port logic.
package mesh_pkg;

  localparam int unsigned PACKET_SIZE = 32;

  typedef enum logic [1:0] {IDLE, SEND, GAP} sched_state_t;

  // Bits needed to hold a credit count in the range 0..depth inclusive.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned IDX_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any_req,
  output logic [IDX_W-1:0]   winner
);

  int unsigned idx;

  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/local_port_scheduler.sv
// Shares the router local input port among NUM_SRC sources with round-robin grants,
// credit-based flow control and an optional idle gap after every packet.
module local_port_scheduler #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned PACKET_SIZE  = mesh_pkg::PACKET_SIZE,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CREDIT_WIDTH = mesh_pkg::credit_width(FIFO_DEPTH),
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic                           rt_clk,
  input  logic                           rt_reset,
  input  logic [NUM_SRC-1:0]             req,
  input  logic [NUM_SRC*PACKET_SIZE-1:0] packet_in,
  output logic [NUM_SRC-1:0]             grant,
  output logic                           write_req,
  output logic [PACKET_SIZE-1:0]         spike_packet,
  input  logic                           credit_return,
  output logic [CREDIT_WIDTH-1:0]        credit_count,
  output logic                           busy,
  output logic                           credit_overflow
);

  import mesh_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_SRC);
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  sched_state_t     state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_q;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] next_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic             any_req;
  logic             start;
  logic             in_send;
  logic             at_full;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .any_req (any_req),
    .winner  (winner)
  );

  assign start    = (state == IDLE) && any_req && (credit_count != '0);
  assign in_send  = (state == SEND);
  assign at_full  = (credit_count == CREDIT_WIDTH'(FIFO_DEPTH));
  assign next_ptr = (win_q == IDX_W'(NUM_SRC - 1)) ? '0 : win_q + 1'b1;
  assign busy     = (state != IDLE);

  // grant/write_req/spike_packet are loaded on the IDLE->SEND edge so they are
  // valid for exactly the SEND cycle.
  always_ff @(posedge rt_clk or posedge rt_reset) begin
    if (rt_reset) begin
      state        <= IDLE;
      grant        <= '0;
      write_req    <= 1'b0;
      spike_packet <= '0;
      rr_ptr       <= '0;
      win_q        <= '0;
      gap_cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= SEND;
            win_q        <= winner;
            grant        <= NUM_SRC'(1) << winner;
            write_req    <= 1'b1;
            spike_packet <= packet_in[winner*PACKET_SIZE +: PACKET_SIZE];
          end
        end
        SEND: begin
          grant     <= '0;
          write_req <= 1'b0;
          rr_ptr    <= next_ptr;
          if (GAP_CYCLES > 0) begin
            state   <= GAP;
            gap_cnt <= GAP_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES)) begin
            state   <= IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A send and a returned credit in the same cycle cancel out.
  always_ff @(posedge rt_clk or posedge rt_reset) begin
    if (rt_reset) begin
      credit_count    <= CREDIT_WIDTH'(FIFO_DEPTH);
      credit_overflow <= 1'b0;
    end else if (in_send && !credit_return) begin
      credit_count <= credit_count - 1'b1;
    end else if (credit_return && !in_send) begin
      if (at_full) begin
        credit_overflow <= 1'b1;
      end else begin
        credit_count <= credit_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_local_port_scheduler.sv
// Directed bench for local_port_scheduler with a grant/packet scoreboard.
module tb_local_port_scheduler;

  localparam int NS = 4;
  localparam int PS = 32;
  localparam int FD = 8;
  localparam int CW = 4;
  localparam int GC = 4;

  logic              rt_clk = 1'b0;
  logic              rt_reset = 1'b0;
  logic [NS-1:0]     req = '0;
  logic [NS*PS-1:0]  packet_in = '0;
  logic              credit_return = 1'b0;
  logic [NS-1:0]     grant;
  logic              write_req;
  logic [PS-1:0]     spike_packet;
  logic [CW-1:0]     credit_count;
  logic              busy;
  logic              credit_overflow;

  local_port_scheduler #(
    .NUM_SRC      (NS),
    .PACKET_SIZE  (PS),
    .FIFO_DEPTH   (FD),
    .CREDIT_WIDTH (CW),
    .GAP_CYCLES   (GC)
  ) dut (
    .rt_clk          (rt_clk),
    .rt_reset        (rt_reset),
    .req             (req),
    .packet_in       (packet_in),
    .grant           (grant),
    .write_req       (write_req),
    .spike_packet    (spike_packet),
    .credit_return   (credit_return),
    .credit_count    (credit_count),
    .busy            (busy),
    .credit_overflow (credit_overflow)
  );

  always #5 rt_clk = ~rt_clk;

  int cyc = 0;
  always @(posedge rt_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [NS-1:0] g;
    logic [PS-1:0] p;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_send = 0;
  int   pulses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge rt_clk);
      #1;
    end
  endtask

  task automatic set_pkt(input int i, input logic [PS-1:0] v);
    packet_in[i*PS +: PS] = v;
  endtask

  task automatic push(input logic [NS-1:0] g, input logic [PS-1:0] p);
    exp_t e;
    e.g = g;
    e.p = p;
    sb.push_back(e);
  endtask

  // Wait (bounded) for a write strobe, then compare it with the scoreboard head.
  task automatic expect_send(input string tag);
    exp_t e;
    int   k = 0;
    while (write_req !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    if (write_req !== 1'b1) begin
      check({tag, " timeout"}, 64'(write_req), 64'd1);
    end else if (sb.size() == 0) begin
      check({tag, " unexpected send"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " grant"}, 64'(grant), 64'(e.g));
      check({tag, " packet"}, 64'(spike_packet), 64'(e.p));
    end
  endtask

  task automatic do_reset();
    @(negedge rt_clk);
    rt_reset = 1'b1;
    @(negedge rt_clk);
    rt_reset = 1'b0;
    @(posedge rt_clk);
    #1;
  endtask

  task automatic pulse_credit(input int n);
    repeat (n) begin
      credit_return = 1'b1;
      tick();
      credit_return = 1'b0;
      tick();
    end
  endtask

  initial begin
    exp_t e;
    #1 rt_reset = 1'b1;
    tick(2);
    check("rst grant", 64'(grant), 64'd0);
    check("rst write_req", 64'(write_req), 64'd0);
    check("rst spike_packet", 64'(spike_packet), 64'd0);
    check("rst credit_count", 64'(credit_count), 64'd8);
    check("rst busy", 64'(busy), 64'd0);
    check("rst overflow", 64'(credit_overflow), 64'd0);
    #2 rt_reset = 1'b0;
    tick(2);

    // Single source, one-cycle latency, gap timing.
    set_pkt(2, 32'hA5A5_0001);
    req = 4'b0100;
    push(4'b0100, 32'hA5A5_0001);
    tick();
    check("t1 latency", 64'(write_req), 64'd1);
    expect_send("t1");
    check("t1 busy in send", 64'(busy), 64'd1);
    req = '0;
    tick();
    check("t1 credit 7", 64'(credit_count), 64'd7);
    check("t1 write_req drop", 64'(write_req), 64'd0);
    check("t1 grant drop", 64'(grant), 64'd0);
    tick(3);
    check("t1 busy in gap", 64'(busy), 64'd1);
    tick();
    check("t1 busy low", 64'(busy), 64'd0);
    pulse_credit(1);
    check("t1 credit back", 64'(credit_count), 64'd8);

    // Round-robin fairness with all sources requesting.
    do_reset();
    for (int i = 0; i < NS; i++) set_pkt(i, 32'h1000_0000 + i);
    for (int s = 0; s < 5; s++) push(4'(1 << (s % NS)), 32'h1000_0000 + (s % NS));
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      expect_send("t2 rr");
      if (s > 0) check("t2 spacing", 64'(cyc - last_send), 64'd6);
      last_send = cyc;
      tick();
    end
    check("t2 credit 3", 64'(credit_count), 64'd3);
    req = '0;

    // Credit exhaustion: exactly FIFO_DEPTH sends, then one more per returned credit.
    do_reset();
    set_pkt(0, 32'hC0DE_0000);
    for (int s = 0; s < FD; s++) push(4'b0001, 32'hC0DE_0000);
    req = 4'b0001;
    pulses = 0;
    repeat (FD * 6 + 20) begin
      tick();
      if (write_req === 1'b1) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("t3 grant", 64'(grant), 64'(e.g));
        end
      end
    end
    check("t3 pulses", 64'(pulses), 64'(FD));
    check("t3 credit 0", 64'(credit_count), 64'd0);
    check("t3 idle blocked", 64'(busy), 64'd0);
    push(4'b0001, 32'hC0DE_0000);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    expect_send("t3 extra");
    tick();
    pulses = 0;
    repeat (20) begin
      tick();
      if (write_req === 1'b1) pulses++;
    end
    check("t3 no more sends", 64'(pulses), 64'd0);
    req = '0;

    // Simultaneous send and credit return leaves the count unchanged.
    pulse_credit(5);
    check("t4 credit 5", 64'(credit_count), 64'd5);
    push(4'b0001, 32'hC0DE_0000);
    req = 4'b0001;
    tick();
    expect_send("t4");
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    req = '0;
    check("t4 credit unchanged", 64'(credit_count), 64'd5);

    // Overflow: extra credit at full is ignored and latched as an error.
    pulse_credit(3);
    check("t5 credit full", 64'(credit_count), 64'd8);
    check("t5 no overflow yet", 64'(credit_overflow), 64'd0);
    pulse_credit(1);
    check("t5 credit capped", 64'(credit_count), 64'd8);
    check("t5 overflow set", 64'(credit_overflow), 64'd1);
    tick(10);
    check("t5 overflow sticky", 64'(credit_overflow), 64'd1);

    // Reset during SEND aborts the grant and clears rr_ptr.
    do_reset();
    check("t6 overflow cleared", 64'(credit_overflow), 64'd0);
    set_pkt(1, 32'h0000_B001);
    set_pkt(2, 32'h0000_B002);
    set_pkt(3, 32'h0000_B003);
    push(4'b0010, 32'h0000_B001);
    req = 4'b0010;
    tick();
    expect_send("t6 pre");
    req = '0;
    tick(6);
    req = 4'b0100;
    tick();
    check("t6 in send", 64'(write_req), 64'd1);
    #2 rt_reset = 1'b1;
    #1;
    check("t6 async grant", 64'(grant), 64'd0);
    check("t6 async write_req", 64'(write_req), 64'd0);
    check("t6 async credit", 64'(credit_count), 64'd8);
    check("t6 async busy", 64'(busy), 64'd0);
    @(negedge rt_clk);
    rt_reset = 1'b0;
    req = 4'b1010;
    push(4'b0010, 32'h0000_B001);
    tick();
    expect_send("t6 post");
    req = '0;
    tick(8);
    check("sb drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/local_port_scheduler.md
Name: local_port_scheduler

Overview:
- Router-clock-domain scheduler that shares one router local input port among NUM_SRC packet sources, for example the spike injection path and the neuron spike output path.
- Arbitration is round-robin, one packet per grant.
- Credit-based flow control tracks free slots in the router local FIFO, so the port can never be overrun.
- A programmable inter-packet gap (GAP_CYCLES) enforces a minimum spacing between packets.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- PACKET_SIZE, 32, packet width in bits.
- FIFO_DEPTH, 8, router local FIFO depth; also the initial and maximum credit count.
- CREDIT_WIDTH, 4, credit counter width; must satisfy 2**CREDIT_WIDTH > FIFO_DEPTH.
- GAP_CYCLES, 4, idle cycles inserted after each sent packet (0 = back-to-back allowed).

Ports:
- rt_clk  in  1  router clock; all logic is on its rising edge.
- rt_reset  in  1  asynchronous, active-high reset.
- req  in  NUM_SRC  per-source request; held high with its packet stable until granted.
- packet_in  in  NUM_SRC*PACKET_SIZE  source i occupies bits [i*PACKET_SIZE +: PACKET_SIZE].
- grant  out  NUM_SRC  one-hot, one-cycle pulse; the source's packet has been taken.
- write_req  out  1  one-cycle write strobe to the router local port.
- spike_packet  out  PACKET_SIZE  packet valid while write_req=1.
- credit_return  in  1  one pulse per packet the router drains from its local FIFO.
- credit_count  out  CREDIT_WIDTH  current free-slot count.
- busy  out  1  high in any state other than IDLE.
- credit_overflow  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Single clock rt_clk; reset rt_reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, grant=0, write_req=0, spike_packet=0.
  - credit_count=FIFO_DEPTH, rr_ptr=0, gap counter=0, credit_overflow=0.
  - Reset asserted mid-operation aborts any SEND/GAP immediately; the in-flight grant is not issued.
- FSM, three states:
  - IDLE: if (|req) and credit_count>0, the winner is taken combinationally and the FSM goes to SEND. On that edge the winner index and packet_in slice are registered. Otherwise the FSM stays in IDLE.
  - SEND, exactly one cycle: write_req=1, spike_packet=captured packet, grant[winner]=1, rr_ptr <= (winner+1) mod NUM_SRC. Next state is GAP if GAP_CYCLES>0, else IDLE.
  - GAP: counter runs from 1 up to GAP_CYCLES. When it reaches GAP_CYCLES the FSM goes to IDLE and the counter clears. Requests are ignored during GAP.
- Latency: req seen in IDLE at cycle t gives write_req and grant at t+1. Minimum packet spacing is GAP_CYCLES+2 cycles, or 2 when GAP_CYCLES=0.
- Round-robin:
  - The search starts at rr_ptr and wraps at NUM_SRC-1 to 0; the first asserted req wins.
  - A source dropping req before its grant is legal; it simply loses its turn.
- Credits:
  - Decrement by 1 in SEND; increment by 1 on credit_return.
  - If SEND and credit_return happen in the same cycle, the count is unchanged.
  - credit_return when credit_count==FIFO_DEPTH (and not SEND) is ignored and sets credit_overflow.
  - credit_count==0 blocks arbitration; requests wait in IDLE with no grant.
- grant and write_req are registered outputs and never assert outside SEND.

Decomposition:
- Shared package mesh_pkg:
  - PACKET_SIZE constant.
  - State enum sched_state_t {IDLE, SEND, GAP}.
  - Helper function for the credit width.
- One sub-module, rr_arbiter:
  - Parameter NUM_SRC.
  - Inputs req and ptr; outputs any_req and the winner index.
  - Purely combinational; instanced once.

Test Plan:
- Single source, no contention: NUM_SRC=4, GAP_CYCLES=4; req[2]=1 with packet 32'hA5A5_0001 at cycle 10 -> write_req and grant=4'b0100 at cycle 11, spike_packet=A5A5_0001, credit_count 8->7, busy low again at cycle 16.
- Round-robin fairness: req=4'b1111 held continuously -> grants in order 0,1,2,3,0 with 6-cycle spacing; credit_count reaches 3 after 5 sends with no credit_return.
- Credit exhaustion: FIFO_DEPTH=8, no credit_return, req[0] held -> exactly 8 write_req pulses, then none. One credit_return pulse -> one more send.
- Simultaneous SEND and credit_return: credit_count=5, credit_return asserted in the SEND cycle -> credit_count remains 5.
- Overflow: credit_count=8, credit_return pulse -> count stays 8, credit_overflow=1 and stays 1 until rt_reset.
- Reset mid-operation: assert rt_reset during the SEND cycle -> grant and write_req drop asynchronously, credit_count=8, rr_ptr=0. After release, req=4'b1010 -> first grant goes to source 1.
